// File: rtl/mux_rr_sel.sv
// Registered N-channel mux with per-channel valid/ready, manual or round-robin select.
// Round-robin mode and its pointer exist only when MUX_RR_EN is defined.
module mux_rr_sel #(
    parameter int W = 8,
    parameter int N = 4,
    localparam int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    input  logic           mode,
    input  logic [SW-1:0]  sel,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_ch,
    output logic           out_valid,
    input  logic           out_ready
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t        r_state;
    logic [W-1:0]  r_data;
    logic [SW-1:0] r_ch;

    logic          w_man_hit;
    logic [SW-1:0] w_man_g;
    logic          w_rr_mode;
    logic          w_rr_hit;
    logic [SW-1:0] w_rr_g;
    logic          w_hit;
    logic [SW-1:0] w_g;
    logic          w_load_en;
    logic          w_xfer;
    logic [W-1:0]  w_gdata;

    // An out-of-range sel matches no loop index, so it can never grant.
    always_comb begin
        w_man_hit = 1'b0;
        w_man_g   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (sel == SW'(i) && in_valid[i]) begin
                w_man_hit = 1'b1;
                w_man_g   = SW'(i);
            end
        end
    end

`ifdef MUX_RR_EN
    logic [SW-1:0] r_ptr;
    int unsigned   w_idx;

    assign w_rr_mode = mode;

    always_comb begin
        w_rr_hit = 1'b0;
        w_rr_g   = '0;
        w_idx    = 0;
        for (int unsigned k = 0; k < N; k++) begin
            w_idx = (int'(r_ptr) + k) % N;
            if (!w_rr_hit && in_valid[SW'(w_idx)]) begin
                w_rr_hit = 1'b1;
                w_rr_g   = SW'(w_idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_xfer && w_rr_mode) begin
            r_ptr <= SW'((int'(w_g) + 1) % N);
        end
    end
`else
    logic w_unused_mode;

    assign w_unused_mode = mode;
    assign w_rr_mode     = 1'b0;
    assign w_rr_hit      = 1'b0;
    assign w_rr_g        = '0;
`endif

    assign w_hit     = w_rr_mode ? w_rr_hit : w_man_hit;
    assign w_g       = w_rr_mode ? w_rr_g   : w_man_g;
    // rst_n gates load_en so in_ready stays low while reset is held.
    assign w_load_en = rst_n && ((r_state == EMPTY) || out_ready);
    assign w_xfer    = w_load_en && w_hit;

    always_comb begin
        in_ready = '0;
        w_gdata  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (w_g == SW'(i)) begin
                in_ready[i] = w_xfer;
                w_gdata     = in_data[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
            r_data  <= '0;
            r_ch    <= '0;
        end else if (w_xfer) begin
            r_state <= FULL;
            r_data  <= w_gdata;
            r_ch    <= w_g;
        end else if (r_state == FULL && out_ready) begin
            r_state <= EMPTY;
        end
    end

    assign out_valid = (r_state == FULL);
    assign out_data  = r_data;
    assign out_ch    = r_ch;

endmodule

// File: tb/tb_mux_rr_sel.sv
// Directed bench for mux_rr_sel: a 4-channel and a 3-channel instance.
// Round-robin vectors run only when MUX_RR_EN is defined; otherwise manual-only vectors run.
module tb_mux_rr_sel;

    logic        clk;
    logic        rst_n;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic        mode;
    logic [1:0]  sel;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_valid;
    logic        out_ready;

    logic [23:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic        mode3;
    logic [1:0]  sel3;
    logic [7:0]  out_data3;
    logic [1:0]  out_ch3;
    logic        out_valid3;
    logic        out_ready3;

    int n_checks;
    int n_fail;

    mux_rr_sel #(.W(8), .N(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
        .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
    );

    mux_rr_sel #(.W(8), .N(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3),
        .in_ready(in_ready3), .mode(mode3), .sel(sel3), .out_data(out_data3),
        .out_ch(out_ch3), .out_valid(out_valid3), .out_ready(out_ready3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks one registered output word after the next edge.
    task automatic expect_word(input string tag, input logic [7:0] d, input logic [1:0] ch);
        tick();
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"},  32'(out_data),  32'(d));
        check({tag, "_ch"},    32'(out_ch),    32'(ch));
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        in_data    = 32'h13121110;
        in_valid   = 4'b1111;
        mode       = 1'b0;
        sel        = 2'd0;
        out_ready  = 1'b1;
        in_data3   = 24'h222120;
        in_valid3  = 3'b000;
        mode3      = 1'b0;
        sel3       = 2'd0;
        out_ready3 = 1'b1;

        // Reset held: everything clear, in_ready gated.
        #12;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data",  32'(out_data),  32'h00);
        check("rst_ch",    32'(out_ch),    32'd0);
        check("rst_ready", 32'(in_ready),  32'd0);
        in_valid = 4'b0000;
        #1;
        rst_n = 1'b1;
        tick();

        // Manual grant on channel 2.
        mode     = 1'b0;
        sel      = 2'd2;
        in_data  = 32'h00A50000;
        in_valid = 4'b0100;
        #1;
        check("man_ready", 32'(in_ready), 32'h4);
        expect_word("man", 8'hA5, 2'd2);

        // sel points at an idle channel: word drains, nothing reloads.
        sel      = 2'd1;
        in_valid = 4'b0001;
        #1;
        check("man_noready", 32'(in_ready), 32'h0);
        tick();
        check("man_drain_valid", 32'(out_valid), 32'd0);
        check("man_drain_data",  32'(out_data),  32'hA5);
        check("man_drain_ch",    32'(out_ch),    32'd2);

        // Backpressure: load 0x3C then stall for 5 cycles with changing inputs.
        sel       = 2'd0;
        in_data   = 32'h0000003C;
        in_valid  = 4'b0001;
        out_ready = 1'b0;
        #1;
        check("bp_load_ready", 32'(in_ready), 32'h1);
        expect_word("bp_load", 8'h3C, 2'd0);
        for (int i = 0; i < 5; i++) begin
            sel      = 2'(i + 1);
            in_valid = 4'b1111;
            in_data  = 32'h77665544 + 32'(i);
            #1;
            check("bp_ready", 32'(in_ready), 32'h0);
            tick();
            check("bp_hold_data",  32'(out_data),  32'h3C);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
        end
        sel       = 2'd3;
        in_data   = 32'h77000000;
        in_valid  = 4'b1000;
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'h8);
        expect_word("bp_reload", 8'h77, 2'd3);
        in_valid = 4'b0000;
        tick();
        check("bp_empty", 32'(out_valid), 32'd0);

        in_data = 32'h13121110;
`ifdef MUX_RR_EN
        // Round-robin over all four channels, pointer starts at 0.
        mode     = 1'b1;
        sel      = 2'd2;
        in_valid = 4'b1111;
        #1;
        check("rr_first_ready", 32'(in_ready), 32'h1);
        expect_word("rr_a0", 8'h10, 2'd0);
        expect_word("rr_a1", 8'h11, 2'd1);
        expect_word("rr_a2", 8'h12, 2'd2);
        expect_word("rr_a3", 8'h13, 2'd3);
        expect_word("rr_a4", 8'h10, 2'd0);
        // Pointer now 1: alternates between channels 1 and 3.
        in_valid = 4'b1010;
        expect_word("rr_b0", 8'h11, 2'd1);
        expect_word("rr_b1", 8'h13, 2'd3);
        expect_word("rr_b2", 8'h11, 2'd1);
        expect_word("rr_b3", 8'h13, 2'd3);
`else
        // Without round-robin support mode is ignored; sel alone decides.
        mode     = 1'b1;
        sel      = 2'd1;
        in_valid = 4'b1111;
        #1;
        check("mo_ready", 32'(in_ready), 32'h2);
        for (int i = 0; i < 4; i++) expect_word("mo_grant", 8'h11, 2'd1);
`endif

        // Reset mid-stream with a word held: clears at once.
        check("mid_pre_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_data",  32'(out_data),  32'h00);
        check("mid_rst_ch",    32'(out_ch),    32'd0);
        check("mid_rst_ready", 32'(in_ready),  32'd0);
        mode     = 1'b1;
        sel      = 2'd0;
        in_valid = 4'b1111;
        #1;
        check("mid_rst_ready2", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", 32'(in_ready), 32'h1);
        expect_word("post_rst", 8'h10, 2'd0);

        // N=3 instance: sel=3 is out of range and never grants.
        mode3     = 1'b0;
        sel3      = 2'd3;
        in_valid3 = 3'b111;
        #1;
        check("oor_ready", 32'(in_ready3), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("oor_valid", 32'(out_valid3), 32'd0);
        end
        sel3 = 2'd2;
        #1;
        check("n3_ready", 32'(in_ready3), 32'h4);
        tick();
        check("n3_data", 32'(out_data3), 32'h22);
        check("n3_ch",   32'(out_ch3),   32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
